// File: rtl/calc_pkg.sv
// calc_pkg: shared FSM states, seven-segment glyphs and widths for the result display
package calc_pkg;
  localparam int DATA_W     = 16;
  localparam int BCD_W      = 20;
  localparam int NUM_DIGITS = 6;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  function automatic logic [6:0] seg_glyph(input logic [3:0] d);
    case (d)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/result_display_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble, 16-bit magnitude to five BCD digits over 16 steps
module bin2bcd_seq
  import calc_pkg::*;
(
  input  logic              clk,
  input  logic              nRST,
  input  logic              start,
  input  logic [DATA_W-1:0] magnitude,
  output logic [BCD_W-1:0]  bcd,
  output logic              done
);
  logic [DATA_W-1:0] sr;
  logic [BCD_W-1:0]  adj;
  logic [4:0]        cnt;
  assign done = cnt == 5'd16;
  // add-3 correction of every digit that would overflow on the next shift
  always_comb begin
    adj = bcd;
    for (int i = 0; i < BCD_W / 4; i++)
      adj[i*4 +: 4] = bcd[i*4 +: 4] >= 4'd5 ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
  end
  // the load edge already performs the first step, since a zero BCD needs no correction
  always_ff @(posedge clk) begin
    if (!nRST) begin
      bcd <= '0;
      sr  <= '0;
      cnt <= 5'd16;
    end else if (start) begin
      bcd <= {{(BCD_W-1){1'b0}}, magnitude[DATA_W-1]};
      sr  <= {magnitude[DATA_W-2:0], 1'b0};
      cnt <= 5'd1;
    end else if (!done) begin
      {bcd, sr} <= {adj, sr} << 1;
      cnt       <= cnt + 5'd1;
    end
  end
endmodule

// File: rtl/result_display.sv
// result_display: signed result to BCD plus six-position multiplexed seven-segment driver; LEADING_ZERO_BLANK_EN blanks leading zeros
module result_display
  import calc_pkg::*;
#(
  parameter int REFRESH_DIV = 1024
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic [DATA_W-1:0] display_value,
  input  logic              complete,
  output logic              busy,
  output logic              ready,
  output logic              negative,
  output logic [BCD_W-1:0]  bcd_out,
  output logic [6:0]        seg,
  output logic [5:0]        an
);
  localparam int DW = REFRESH_DIV > 2 ? $clog2(REFRESH_DIV) : 1;
  state_t            state, state_nx;
  logic              complete_q, evt_q, pending, sign, start, done;
  logic [DATA_W-1:0] mag;
  logic [BCD_W-1:0]  bcd;
  logic [DW-1:0]     div_cnt;
  logic [2:0]        pos;
  logic [23:0]       digits;
  logic [3:0]        nib;
  logic              blank;
  assign mag    = display_value[DATA_W-1] ? ~display_value + 16'd1 : display_value;
  assign busy   = state != IDLE;
  assign digits = {4'h0, bcd_out};
  assign nib    = digits[{pos, 2'b00} +: 4];
  assign an     = ~(6'b1 << pos);
  bin2bcd_seq u_bin2bcd (
    .clk       (clk),
    .nRST      (nRST),
    .start     (start),
    .magnitude (mag),
    .bcd       (bcd),
    .done      (done)
  );
  // a new conversion starts from IDLE on an event, or straight from DONE when one is pending
  always_comb begin
    start    = (state == IDLE && evt_q) || (state == DONE && (pending || evt_q));
    state_nx = start ? SHIFT : (state == SHIFT && done) ? DONE : state == DONE ? IDLE : state;
  end
  // control state, edge detection and publication of the finished digits
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state      <= IDLE;
      complete_q <= 1'b0;
      evt_q      <= 1'b0;
      pending    <= 1'b0;
      sign       <= 1'b0;
      ready      <= 1'b0;
      negative   <= 1'b0;
      bcd_out    <= '0;
    end else begin
      state      <= state_nx;
      complete_q <= complete;
      evt_q      <= complete & ~complete_q;
      pending    <= start ? 1'b0 : pending | (evt_q && state != IDLE);
      ready      <= state == DONE;
      if (start) sign <= display_value[DATA_W-1];
      if (state == DONE) begin
        bcd_out  <= bcd;
        negative <= sign && bcd != '0;
      end
    end
  end
  // scan position advances once every REFRESH_DIV cycles
  always_ff @(posedge clk) begin
    if (!nRST) begin
      div_cnt <= '0;
      pos     <= 3'd0;
    end else if (div_cnt == DW'(REFRESH_DIV - 1)) begin
      div_cnt <= '0;
      pos     <= pos == 3'(NUM_DIGITS - 1) ? 3'd0 : pos + 3'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end
  // glyph for the active position; the top position carries only the sign
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    blank = pos != 3'd0 && (digits >> {pos, 2'b00}) == 24'd0;
`else
    blank = 1'b0;
`endif
    seg = pos == 3'(NUM_DIGITS - 1) ? (negative ? SEG_MINUS : SEG_BLANK) : blank ? SEG_BLANK : seg_glyph(nib);
  end
endmodule

// File: doc/result_display.md
RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 SHALL have parameter: REFRESH_DIV, default 1024, clk cycles per digit-scan slot (>=2).
REQ-002 SHALL have port: clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: nRST  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port: display_value  input  16  signed two's-complement calculation result.
REQ-005 SHALL have port: complete  input  1  result-ready level from calculator controller.
REQ-006 SHALL have port: busy  output  1  conversion in progress.
REQ-007 SHALL have port: ready  output  1  one-cycle pulse, new digits published.
REQ-008 SHALL have port: negative  output  1  sign of published result.
REQ-009 SHALL have port: bcd_out  output  20  five BCD digits, [19:16] = ten-thousands.
REQ-010 SHALL have port: seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-011 SHALL have port: an  output  6  active-low digit enables; an[5] = sign position, an[0] = units.

Function
REQ-012 SHALL detect load events as rising edges of complete (complete=1, registered previous value=0); level-high complete SHALL NOT retrigger.
REQ-013 SHALL use FSM states IDLE, SHIFT, DONE; IDLE->SHIFT on load event, SHIFT->DONE after 16 shift cycles, DONE->IDLE unconditionally.
REQ-014 On IDLE->SHIFT SHALL capture sign = display_value[15] and magnitude = sign ? (~display_value + 1) : display_value, as 16-bit unsigned (0x8000 -> 32768).
REQ-015 In SHIFT SHALL perform one double-dabble step per cycle: add 3 to each BCD nibble >=5, then shift {bcd, magnitude} left by one.
REQ-016 In DONE SHALL update bcd_out and negative together and assert ready for exactly that cycle; ready SHALL occur 18 cycles after the edge sampling the load event.
REQ-017 busy SHALL be 1 in SHIFT and DONE, 0 in IDLE.
REQ-018 bcd_out, negative, seg and an SHALL hold previously published values throughout a conversion.
REQ-019 A load event during SHIFT or DONE SHALL set a pending flag; DONE SHALL then go to SHIFT with the current display_value instead of IDLE; further events SHALL collapse into one pending.
REQ-020 negative SHALL be 0 when published magnitude is 0.
REQ-021 Scan counter SHALL advance the active position 0,1,...,5,0 every REFRESH_DIV cycles; exactly one an bit low at a time.
REQ-022 Position 5 SHALL show '-' (seg=7'b0111111) when negative, blank (7'b1111111) otherwise; positions 0-4 SHALL show the decimal glyph of the corresponding bcd_out nibble.

Reset
REQ-023 On nRST=0 at clk edge: state IDLE, pending 0, busy 0, ready 0, negative 0, bcd_out 0, scan position 0, an=6'b111110, seg = glyph '0' (7'b1000000).
REQ-024 Reset mid-conversion SHALL abandon the conversion with no ready pulse; the complete-edge register SHALL reset to 0.

Configuration
REQ-025 With LEADING_ZERO_BLANK_EN defined, positions 4..1 SHALL be blanked while they and all higher digits are zero; position 0 SHALL never be blanked.
REQ-026 Without LEADING_ZERO_BLANK_EN, all five digit positions SHALL always show their glyph; bcd_out SHALL be identical in both builds.

Structure
REQ-027 Package calc_pkg SHALL hold the FSM state enum, seven-segment glyph constants (0-9, minus, blank) and the digit-count constant (6).
REQ-028 Double-dabble datapath SHALL be sub-module bin2bcd_seq (start, magnitude in; bcd, done out); scan/decode SHALL remain in result_display.

Verification
REQ-029 display_value=16'd1234, complete rising -> ready 18 cycles later, bcd_out=20'h01234, negative=0.
REQ-030 display_value=16'hFFFF -> bcd_out=20'h00001, negative=1; position 5 seg=7'b0111111.
REQ-031 display_value=16'h8000 -> bcd_out=20'h32768, negative=1; display_value=16'h7FFF -> 20'h32767, negative=0.
REQ-032 display_value=0, complete held high 40 cycles -> exactly one ready, negative=0; with LEADING_ZERO_BLANK_EN only an[0] slot shows '0', others blank.
REQ-033 Second complete rising edge 5 cycles into SHIFT with new value 16'd42 -> first ready, then second conversion with no IDLE cycle, ready 17 cycles later, bcd_out=20'h00042.
REQ-034 nRST low for one cycle at SHIFT cycle 8 -> no ready, all outputs at REQ-023 values, next complete edge converts normally.
